// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM pattern tester: FSM state codes,
// pattern selector and the 16-bit Galois LFSR step.
package sdram_test_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'h0,
        ST_WRITE     = 4'h1,
        ST_READ_REQ  = 4'h2,
        ST_READ_RESP = 4'h3,
        ST_DONE_PASS = 4'hA,
        ST_DONE_FAIL = 4'hF
    } test_state_e;

    typedef enum logic [1:0] {
        PAT_ADDR     = 2'd0,
        PAT_INV_ADDR = 2'd1,
        PAT_LFSR     = 2'd2,
        PAT_WALK_ONE = 2'd3
    } pattern_sel_e;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Test-pattern generator shared by the write and readback phases.
// Word k of an LFSR run is the seed stepped k+1 times.
module sdram_pattern_gen
    import sdram_test_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart_i,
    input  logic                  advance_i,
    input  pattern_sel_e          sel_i,
    input  logic [15:0]           seed_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned REP = (DATA_WIDTH + 15) / 16;

    logic [15:0]           lfsr_q, lfsr_d, lfsr_next;
    logic [ADDR_WIDTH-1:0] bit_pos;
    logic [DATA_WIDTH-1:0] addr_word, lfsr_word;

    always_comb begin
        lfsr_next = lfsr_step(lfsr_q);
        lfsr_d    = lfsr_q;
        if (restart_i) begin
            lfsr_d = (seed_i == '0) ? LFSR_DEFAULT_SEED : seed_i;
        end else if (advance_i) begin
            lfsr_d = lfsr_next;
        end

        addr_word = DATA_WIDTH'(addr_i);
        bit_pos   = addr_i % ADDR_WIDTH'(DATA_WIDTH);
        lfsr_word = DATA_WIDTH'({REP{lfsr_next}});

        data_o = addr_word;
        case (sel_i)
            PAT_ADDR:     data_o = addr_word;
            PAT_INV_ADDR: data_o = ~addr_word;
            PAT_LFSR:     data_o = lfsr_word;
            PAT_WALK_ONE: data_o = DATA_WIDTH'(1) << bit_pos;
            default:      data_o = addr_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test engine: writes a window with a selectable pattern, reads it
// back burst by burst and compares. Optional first-error capture: SDRAM_TESTER_ERR_CAPTURE_EN.
module sdram_pattern_tester
    import sdram_test_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BURST_LENGTH = 8,
    parameter int unsigned START_ADDR   = 0,
    parameter int unsigned TEST_WORDS   = 4096,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  clk_axi,
    input  logic                  rst_axi,
    input  logic                  start_i,
    input  logic                  loop_i,
    input  logic [1:0]            pattern_sel_i,
    input  logic [15:0]           seed_i,
    output logic                  writer_valid_o,
    input  logic                  writer_ready_i,
    output logic [ADDR_WIDTH-1:0] writer_addr_o,
    output logic [DATA_WIDTH-1:0] writer_data_o,
    output logic                  reader_valid_o,
    input  logic                  reader_ready_i,
    output logic [ADDR_WIDTH-1:0] reader_addr_o,
    input  logic                  resp_valid_i,
    input  logic                  resp_last_i,
    input  logic [DATA_WIDTH-1:0] resp_data_i,
    output logic                  resp_ready_o,
    output logic [3:0]            test_state_o,
    output logic                  busy_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [CNT_WIDTH-1:0]  err_count_o,
    output logic [CNT_WIDTH-1:0]  pass_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [DATA_WIDTH-1:0] first_err_exp_o,
    output logic [DATA_WIDTH-1:0] first_err_got_o
);

    localparam int unsigned       IDX_W     = $clog2(TEST_WORDS) + 1;
    localparam int unsigned       BEAT_W    = $clog2(BURST_LENGTH) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TEST_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LENGTH - 1);

    test_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    pattern_sel_e         sel_q, sel_d;
    logic [15:0]          seed_q, seed_d;
    logic [CNT_WIDTH-1:0] err_q, err_d, passes_q, passes_d;
    logic                 wvalid_q, wvalid_d, rvalid_q, rvalid_d, rready_q, rready_d;
    logic                 busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [15:0]           gen_seed;
    logic write_fire, read_fire, beat_fire, mismatch, proto_err;
    logic user_start, run_start, gen_restart;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign cur_addr = ADDR_WIDTH'(START_ADDR) + ADDR_WIDTH'(idx_q);
    assign gen_seed = user_start ? seed_i : seed_q;

    sdram_pattern_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_gen (
        .clk       (clk_axi),
        .rst       (rst_axi),
        .restart_i (gen_restart),
        .advance_i (write_fire | beat_fire),
        .sel_i     (sel_q),
        .seed_i    (gen_seed),
        .addr_i    (cur_addr),
        .data_o    (exp_data)
    );

    always_comb begin
        write_fire = wvalid_q & writer_ready_i;
        read_fire  = rvalid_q & reader_ready_i;
        beat_fire  = rready_q & resp_valid_i;
        mismatch   = beat_fire && (resp_data_i != exp_data);
        proto_err  = beat_fire && (resp_last_i != (beat_q == LAST_BEAT));
        user_start = (state_q inside {ST_IDLE, ST_DONE_PASS, ST_DONE_FAIL}) && start_i;
        run_start  = user_start || ((state_q == ST_DONE_PASS) && loop_i);

        state_d  = state_q;
        idx_d    = idx_q;
        beat_d   = beat_q;
        sel_d    = sel_q;
        seed_d   = seed_q;
        err_d    = err_q;
        passes_d = passes_q;

        case (state_q)
            ST_IDLE, ST_DONE_PASS, ST_DONE_FAIL: begin
                // An auto-restart reuses the latched pattern and seed
                if (run_start) begin
                    state_d = ST_WRITE;
                    idx_d   = '0;
                    beat_d  = '0;
                    err_d   = '0;
                    if (user_start) begin
                        sel_d  = pattern_sel_e'(pattern_sel_i);
                        seed_d = seed_i;
                    end
                end
            end
            ST_WRITE: begin
                if (write_fire) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_READ_REQ;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_READ_REQ: begin
                if (read_fire) begin
                    state_d = ST_READ_RESP;
                    beat_d  = '0;
                end
            end
            ST_READ_RESP: begin
                if (beat_fire) begin
                    err_d  = sat_inc(sat_inc(err_q, mismatch), proto_err);
                    idx_d  = idx_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        if (idx_q == LAST_IDX) begin
                            if (err_d == '0) begin
                                state_d  = ST_DONE_PASS;
                                passes_d = sat_inc(passes_q, 1'b1);
                            end else begin
                                state_d = ST_DONE_FAIL;
                            end
                        end else begin
                            state_d = ST_READ_REQ;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        gen_restart = run_start || ((state_q == ST_WRITE) && write_fire && (idx_q == LAST_IDX));
        wvalid_d    = (state_d == ST_WRITE);
        rvalid_d    = (state_d == ST_READ_REQ);
        rready_d    = (state_d == ST_READ_RESP);
        busy_d      = (state_d inside {ST_WRITE, ST_READ_REQ, ST_READ_RESP});
        pass_d      = (state_d == ST_DONE_PASS);
        fail_d      = (state_d == ST_DONE_FAIL);
    end

    always_ff @(posedge clk_axi or posedge rst_axi) begin
        if (rst_axi) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            beat_q   <= '0;
            sel_q    <= PAT_ADDR;
            seed_q   <= '0;
            err_q    <= '0;
            passes_q <= '0;
            wvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rready_q <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
            sel_q    <= sel_d;
            seed_q   <= seed_d;
            err_q    <= err_d;
            passes_q <= passes_d;
            wvalid_q <= wvalid_d;
            rvalid_q <= rvalid_d;
            rready_q <= rready_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

`ifdef SDRAM_TESTER_ERR_CAPTURE_EN
    logic                  cap_done_q, cap_done_d;
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_WIDTH-1:0] cap_exp_q, cap_exp_d, cap_got_q, cap_got_d;

    always_comb begin
        cap_done_d = cap_done_q;
        cap_addr_d = cap_addr_q;
        cap_exp_d  = cap_exp_q;
        cap_got_d  = cap_got_q;
        if (run_start) begin
            cap_done_d = 1'b0;
            cap_addr_d = '0;
            cap_exp_d  = '0;
            cap_got_d  = '0;
        end else if (mismatch && !cap_done_q) begin
            cap_done_d = 1'b1;
            cap_addr_d = cur_addr;
            cap_exp_d  = exp_data;
            cap_got_d  = resp_data_i;
        end
    end

    always_ff @(posedge clk_axi or posedge rst_axi) begin
        if (rst_axi) begin
            cap_done_q <= 1'b0;
            cap_addr_q <= '0;
            cap_exp_q  <= '0;
            cap_got_q  <= '0;
        end else begin
            cap_done_q <= cap_done_d;
            cap_addr_q <= cap_addr_d;
            cap_exp_q  <= cap_exp_d;
            cap_got_q  <= cap_got_d;
        end
    end

    assign first_err_addr_o = cap_addr_q;
    assign first_err_exp_o  = cap_exp_q;
    assign first_err_got_o  = cap_got_q;
`else
    assign first_err_addr_o = '0;
    assign first_err_exp_o  = '0;
    assign first_err_got_o  = '0;
`endif

    // Address/data are forced to zero while their valid is low
    assign writer_valid_o = wvalid_q;
    assign writer_addr_o  = wvalid_q ? cur_addr : '0;
    assign writer_data_o  = wvalid_q ? exp_data : '0;
    assign reader_valid_o = rvalid_q;
    assign reader_addr_o  = rvalid_q ? cur_addr : '0;
    assign resp_ready_o   = rready_q;
    assign test_state_o   = state_q;
    assign busy_o         = busy_q;
    assign pass_o         = pass_q;
    assign fail_o         = fail_q;
    assign err_count_o    = err_q;
    assign pass_count_o   = passes_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester with a small ideal SDRAM model
// (32-word window, 8-beat bursts, 2-cycle read latency).
module tb_sdram_pattern_tester;

    logic        clk_axi = 1'b0;
    logic        rst_axi;
    logic        start_i, loop_i;
    logic [1:0]  pattern_sel_i;
    logic [15:0] seed_i;
    logic        writer_valid_o, writer_ready_i;
    logic [23:0] writer_addr_o;
    logic [15:0] writer_data_o;
    logic        reader_valid_o, reader_ready_i;
    logic [23:0] reader_addr_o;
    logic        resp_valid_i, resp_last_i, resp_ready_o;
    logic [15:0] resp_data_i;
    logic [3:0]  test_state_o;
    logic        busy_o, pass_o, fail_o;
    logic [15:0] err_count_o, pass_count_o;
    logic [23:0] first_err_addr_o;
    logic [15:0] first_err_exp_o, first_err_got_o;

    always #5 clk_axi = ~clk_axi;

    sdram_pattern_tester #(
        .ADDR_WIDTH   (24),
        .DATA_WIDTH   (16),
        .BURST_LENGTH (8),
        .START_ADDR   (0),
        .TEST_WORDS   (32),
        .CNT_WIDTH    (16)
    ) dut (
        .clk_axi          (clk_axi),
        .rst_axi          (rst_axi),
        .start_i          (start_i),
        .loop_i           (loop_i),
        .pattern_sel_i    (pattern_sel_i),
        .seed_i           (seed_i),
        .writer_valid_o   (writer_valid_o),
        .writer_ready_i   (writer_ready_i),
        .writer_addr_o    (writer_addr_o),
        .writer_data_o    (writer_data_o),
        .reader_valid_o   (reader_valid_o),
        .reader_ready_i   (reader_ready_i),
        .reader_addr_o    (reader_addr_o),
        .resp_valid_i     (resp_valid_i),
        .resp_last_i      (resp_last_i),
        .resp_data_i      (resp_data_i),
        .resp_ready_o     (resp_ready_o),
        .test_state_o     (test_state_o),
        .busy_o           (busy_o),
        .pass_o           (pass_o),
        .fail_o           (fail_o),
        .err_count_o      (err_count_o),
        .pass_count_o     (pass_count_o),
        .first_err_addr_o (first_err_addr_o),
        .first_err_exp_o  (first_err_exp_o),
        .first_err_got_o  (first_err_got_o)
    );

    int passes = 0;
    int total  = 0;

    // Driven only by the stimulus process, read by the model
    bit stall_en     = 1'b0;
    int corrupt_addr = -1;
    int force_burst  = -1;

    // SDRAM model state, owned by the model process
    logic [15:0] mem [0:31];
    int          lat, beat, ridx;
    bit          active;
    logic [23:0] burst_addr;
    bit          w_hold, r_hold;
    logic [23:0] w_addr_s, r_addr_s;
    logic [15:0] w_data_s;
    int          stab_checks = 0;
    int          stab_bad    = 0;

    // Ready/response decisions made at negedge apply to the following posedge
    always @(negedge clk_axi) begin
        if (rst_axi) begin
            active = 1'b0; beat = 0; lat = 0;
            w_hold = 1'b0; r_hold = 1'b0;
            writer_ready_i = 1'b0; reader_ready_i = 1'b0;
            resp_valid_i = 1'b0; resp_last_i = 1'b0; resp_data_i = '0;
            for (int i = 0; i < 32; i++) mem[i] = 16'h0BAD;
        end else begin
            if (w_hold) begin
                stab_checks++;
                if (!(writer_valid_o === 1'b1 && writer_addr_o === w_addr_s && writer_data_o === w_data_s))
                    stab_bad++;
            end
            if (r_hold) begin
                stab_checks++;
                if (!(reader_valid_o === 1'b1 && reader_addr_o === r_addr_s)) stab_bad++;
            end

            resp_valid_i = 1'b0; resp_last_i = 1'b0; resp_data_i = '0;
            if (active) begin
                if (lat > 0) begin
                    lat--;
                end else begin
                    ridx = int'(burst_addr) + beat;
                    resp_valid_i = 1'b1;
                    resp_data_i  = (ridx == corrupt_addr) ? 16'hDEAD : mem[ridx[4:0]];
                    resp_last_i  = (beat == 7) || (int'(burst_addr) == force_burst && beat == 3);
                    if (resp_ready_o) begin
                        beat++;
                        if (beat == 8) active = 1'b0;
                    end
                end
            end

            writer_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            reader_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;

            if (writer_valid_o && writer_ready_i) mem[writer_addr_o[4:0]] = writer_data_o;
            w_hold   = writer_valid_o && !writer_ready_i;
            w_addr_s = writer_addr_o;
            w_data_s = writer_data_o;

            if (reader_valid_o && reader_ready_i) begin
                active = 1'b1; beat = 0; lat = 2; burst_addr = reader_addr_o;
            end
            r_hold   = reader_valid_o && !reader_ready_i;
            r_addr_s = reader_addr_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_run(input logic [1:0] sel, input logic [15:0] seed);
        @(negedge clk_axi);
        pattern_sel_i = sel;
        seed_i        = seed;
        start_i       = 1'b1;
        @(posedge clk_axi);
        #1;
        check("start_state", 32'(test_state_o), 32'h1);
        check("start_wvalid", 32'(writer_valid_o), 32'h1);
        check("start_err_clear", 32'(err_count_o), 32'h0);
        @(negedge clk_axi);
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(pass_o || fail_o) && n < 3000) begin
            @(negedge clk_axi);
            n++;
        end
        check("done_reached", 32'(pass_o | fail_o), 32'h1);
    endtask

    initial begin
        rst_axi = 1'b1; start_i = 1'b0; loop_i = 1'b0;
        pattern_sel_i = 2'd0; seed_i = 16'h0;
        repeat (3) @(posedge clk_axi);
        #1;
        check("rst_state", 32'(test_state_o), 32'h0);
        check("rst_status", 32'({busy_o, pass_o, fail_o}), 32'h0);
        check("rst_valids", 32'({writer_valid_o, reader_valid_o, resp_ready_o}), 32'h0);
        check("rst_counts", {err_count_o, pass_count_o}, 32'h0);
        @(negedge clk_axi);
        #2 rst_axi = 1'b0;

        // Address pattern, clean model
        start_run(2'd0, 16'h0);
        wait_done();
        check("p0_state", 32'(test_state_o), 32'hA);
        check("p0_flags", 32'({busy_o, pass_o, fail_o}), 32'b010);
        check("p0_err", 32'(err_count_o), 32'h0);
        check("p0_passcnt", 32'(pass_count_o), 32'h1);
        check("p0_mem5", 32'(mem[5]), 32'h0005);
        check("p0_mem31", 32'(mem[31]), 32'h001F);

        // LFSR with zero seed -> default seed, first word is one step from ACE1
        start_run(2'd2, 16'h0);
        wait_done();
        check("lfsr_w0", 32'(mem[0]), 32'hE270);
        check("lfsr_w1", 32'(mem[1]), 32'h7138);
        check("lfsr_state", 32'(test_state_o), 32'hA);
        check("lfsr_passcnt", 32'(pass_count_o), 32'h2);

        start_run(2'd1, 16'h0);
        wait_done();
        check("inv_mem5", 32'(mem[5]), 32'hFFFA);
        check("inv_state", 32'(test_state_o), 32'hA);

        start_run(2'd3, 16'h0);
        wait_done();
        check("walk_mem5", 32'(mem[5]), 32'h0020);
        check("walk_mem17", 32'(mem[17]), 32'h0002);
        check("walk_passcnt", 32'(pass_count_o), 32'h4);

        // Corrupted readback at address 5
        corrupt_addr = 5;
        start_run(2'd0, 16'h0);
        wait_done();
        corrupt_addr = -1;
        check("corr_state", 32'(test_state_o), 32'hF);
        check("corr_flags", 32'({busy_o, pass_o, fail_o}), 32'b001);
        check("corr_err", 32'(err_count_o), 32'h1);
        check("corr_passcnt", 32'(pass_count_o), 32'h4);
`ifdef SDRAM_TESTER_ERR_CAPTURE_EN
        check("cap_addr", 32'(first_err_addr_o), 32'h5);
        check("cap_exp", 32'(first_err_exp_o), 32'h5);
        check("cap_got", 32'(first_err_got_o), 32'hDEAD);
`else
        check("cap_off", {first_err_addr_o[15:0], first_err_got_o | first_err_exp_o}, 32'h0);
`endif

        // Early resp_last on beat 3 of the burst at address 8
        force_burst = 8;
        start_run(2'd0, 16'h0);
        wait_done();
        force_burst = -1;
        check("last_state", 32'(test_state_o), 32'hF);
        check("last_err", 32'(err_count_o), 32'h1);
        start_run(2'd0, 16'h0);
        wait_done();
        check("rerun_state", 32'(test_state_o), 32'hA);
        check("rerun_err", 32'(err_count_o), 32'h0);
        check("rerun_passcnt", 32'(pass_count_o), 32'h5);

        // Loop mode with random ready stalls
        stall_en = 1'b1;
        loop_i   = 1'b1;
        start_run(2'd2, 16'h1234);
        begin
            int n = 0;
            while (pass_count_o < 16'd8 && n < 8000) begin
                @(negedge clk_axi);
                n++;
            end
        end
        loop_i = 1'b0;
        check("loop_passcnt", 32'(pass_count_o), 32'h8);
        @(posedge clk_axi);
        #1;
        check("loop_stop_state", 32'(test_state_o), 32'hA);
        stall_en = 1'b0;
        check("stall_stable", 32'(stab_bad), 32'h0);
        check("stall_seen", 32'(stab_checks > 0), 32'h1);

        // Reset in the middle of a readback
        start_run(2'd0, 16'h0);
        begin
            int n = 0;
            while (test_state_o != 4'h3 && n < 500) begin
                @(negedge clk_axi);
                n++;
            end
        end
        check("reached_resp", 32'(test_state_o), 32'h3);
        rst_axi = 1'b1;
        #1;
        check("mrst_state", 32'(test_state_o), 32'h0);
        check("mrst_valids", 32'({writer_valid_o, reader_valid_o, resp_ready_o, busy_o, pass_o, fail_o}), 32'h0);
        check("mrst_counts", {err_count_o, pass_count_o}, 32'h0);
        check("mrst_addrs", 32'(writer_addr_o | reader_addr_o | first_err_addr_o), 32'h0);
        repeat (2) @(negedge clk_axi);
        #2 rst_axi = 1'b0;
        start_run(2'd1, 16'h0);
        wait_done();
        check("post_rst_state", 32'(test_state_o), 32'hA);
        check("post_rst_passcnt", 32'(pass_count_o), 32'h1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
